// File: rtl/esm_pkg.sv
// Shared definitions for the ESM feeder and ESM-side logic:
// RV32I opcodes, feeder states and the end-of-stream word.
package esm_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_e;

endpackage

// File: rtl/esm_instr_decoder.sv
// Combinational RV32I opcode decoder producing RegWrite and ALUSrc.
// Unlisted opcodes (store, branch, zero word) decode to 0 where not set.
module esm_instr_decoder
    import esm_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       reg_write_o,
    output logic       alu_src_o
);

    always_comb begin
        reg_write_o = 1'b0;
        alu_src_o   = 1'b0;
        case (opcode_i)
            OP_R: begin
                reg_write_o = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JALR: begin
                reg_write_o = 1'b1;
                alu_src_o   = 1'b1;
            end
            OP_JAL: begin
                reg_write_o = 1'b1;
            end
            OP_STORE: begin
                alu_src_o   = 1'b1;
            end
            default: begin
                reg_write_o = 1'b0;
                alu_src_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/esm_fetch_decode.sv
// Instruction feeder for the ESM buffer: loadable imem, pc walker,
// registered instruction plus decoded control, zero words once done.
module esm_fetch_decode
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = 32,
    parameter int IMEM_DEPTH            = 64,
    parameter int AW                    = $clog2(IMEM_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_we,
    input  logic [AW-1:0]                    load_addr,
    input  logic [Instruction_word_size-1:0] load_data,
    input  logic [AW:0]                      prog_len,
    input  logic                             start,
    input  logic                             stall,
    output logic [Instruction_word_size-1:0] instr_out,
    output logic                             reg_write,
    output logic                             alu_src,
    output logic                             valid,
    output logic                             done,
    output logic [AW-1:0]                    pc
);

    localparam int W = Instruction_word_size;
    localparam logic [AW:0] DEPTH = (AW+1)'(IMEM_DEPTH);

    logic [W-1:0]  imem_q [IMEM_DEPTH];
    state_e        state_q;
    logic [AW:0]   len_q;
    logic [AW:0]   len_d;
    logic [AW-1:0] pc_q;
    logic [W-1:0]  instr_q;
    logic          rw_q;
    logic          as_q;
    logic          valid_q;
    logic          done_q;

    logic [W-1:0]  fetch_w;
    logic          dec_rw;
    logic          dec_as;
    logic          last_d;

    assign fetch_w = imem_q[pc_q];
    assign len_d   = (prog_len > DEPTH) ? DEPTH : prog_len;
    assign last_d  = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

    esm_instr_decoder u_dec (
        .opcode_i    (fetch_w[6:0]),
        .reg_write_o (dec_rw),
        .alu_src_o   (dec_as)
    );

    // Memory is not reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (load_we && state_q == S_IDLE) begin
            imem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            rw_q    <= 1'b0;
            as_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    instr_q <= W'(ZERO_WORD);
                    rw_q    <= 1'b0;
                    as_q    <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= (state_q == S_DONE);
                    if (start) begin
                        if (prog_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            len_q   <= len_d;
                            pc_q    <= '0;
                            state_q <= S_FETCH;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_FETCH: begin
                    if (!stall) begin
                        instr_q <= fetch_w;
                        rw_q    <= dec_rw;
                        as_q    <= dec_as;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + 1'b1;
                        if (last_d) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_out = instr_q;
    assign reg_write = rw_q;
    assign alu_src   = as_q;
    assign valid     = valid_q;
    assign done      = done_q;
    assign pc        = pc_q;

endmodule

// File: doc/esm_fetch_decode.md
# esm_fetch_decode

Upstream feeder for the ESM instruction-buffer stage. Holds a loadable instruction memory, walks a program counter over it, and presents one RV32I instruction per cycle together with its decoded RegWrite/ALUSrc control bits. When the program is exhausted it drives all-zero instruction words, which the downstream ESM treats as end-of-stream and uses to start execution. A stall input freezes issue while the downstream buffer cannot accept.

## Interface
Parameters:
- Instruction_word_size, 32, instruction width in bits
- IMEM_DEPTH, 64, instruction memory entries; power of two
- AW, $clog2(IMEM_DEPTH), derived address width; not to be overridden

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- load_we  in  1  write strobe into instruction memory; honoured only in IDLE
- load_addr  in  AW  write address
- load_data  in  Instruction_word_size  write data
- prog_len  in  AW+1  number of instructions to issue; sampled on accepted start
- start  in  1  begin issue; honoured only in IDLE or DONE
- stall  in  1  downstream cannot accept; freezes pc and all outputs
- instr_out  out  Instruction_word_size  issued instruction; feeds ESM Instr_in
- reg_write  out  1  decoded RegWrite for instr_out
- alu_src  out  1  decoded ALUSrc for instr_out
- valid  out  1  instr_out carries a real instruction
- done  out  1  program fully issued; zero words being driven
- pc  out  AW  address of the next instruction to fetch

## Operation
- States: IDLE, FETCH, DONE. Reset → IDLE.
- IDLE: load writes accepted; outputs zero. start with prog_len==0 → DONE; otherwise len_q ← min(prog_len, IMEM_DEPTH), pc ← 0, → FETCH.
- FETCH, stall=0: instr_out ← imem[pc], control bits ← decode(imem[pc]), valid ← 1, pc ← pc+1. When the issued entry is index len_q−1, next state DONE.
- FETCH, stall=1: pc, instr_out, reg_write, alu_src and valid hold; no state change.
- DONE: instr_out=0, reg_write=0, alu_src=0, valid=0, done=1; held until rst or start. start restarts exactly as from IDLE, using the current memory contents. stall ignored.
- load_we outside IDLE is dropped; memory is not modified.
- start in FETCH is ignored.
- Decode on opcode bits [6:0]:
  - RegWrite=1 for 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
  - ALUSrc=1 for 0010011, 0000011, 0100011, 0110111, 0010111, 1100111.
  - Any other opcode, including 0100011 (store), 1100011 (branch) and all-zero: bits are 0 where not listed above.
- pc wraps modulo IMEM_DEPTH. This occurs only when len_q==IMEM_DEPTH, on the final increment.

## Timing
- Reset values: instr_out=0, reg_write=0, alu_src=0, valid=0, done=0, pc=0, state IDLE. Memory contents are not reset.
- Outputs are registered. start at edge N → first instruction visible after edge N+1.
- With no stall, a program of L instructions occupies L consecutive cycles. done rises on the edge after the last issue; the first zero word appears in the same cycle.
- stall is sampled at the edge. A stall asserted in the cycle before the last issue delays done by the stall length.
- load_we and start in the same IDLE cycle: the write completes, then start takes effect. The fetch at pc=0 sees the new data if load_addr==0.
- rst mid-FETCH: outputs clear immediately, asynchronously. Memory is retained.

## Structure
- Shared package esm_pkg holds:
  - opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  - the state enum
  - the zero-word constant, also used by ESM for its proceed logic
- One sub-module: esm_instr_decoder, combinational, opcode → {reg_write, alu_src}. Reused by ESM-side checks.
- Instruction memory is an inferred register array inside the top.

## Test plan
- Load 3 words: add 0x002081B3, addi 0x00508093, sw 0x0020A023. prog_len=3, start, no stall → instr_out sequence add/addi/sw on 3 consecutive cycles, {reg_write,alu_src} = 10, 11, 01. Next cycle instr_out=0, done=1.
- Same program, stall held for 4 cycles during the second issue → addi held stable for 5 cycles, pc frozen at 2. Third word follows on the first unstalled edge.
- prog_len=0, start → DONE the next cycle. valid never asserts; instr_out stays 0.
- prog_len=IMEM_DEPTH+5 → exactly IMEM_DEPTH words issued, pc wraps to 0, then done.
- load_we to address 1 during FETCH → memory unchanged; a restart from DONE re-issues the original word at address 1.
- rst asserted asynchronously mid-FETCH → all outputs 0 before the next edge. After start, the previously loaded program re-issues intact.
